// File: rtl/id_stage.sv
// Decode stage: register file, hazard scoreboard with replay buffer, and early branch resolution.
// Define ID_BYPASS_EN for write-through register reads and a two-slot (EX/MEM) scoreboard.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        delay,
  input  logic [31:0] ins,
  output logic [34:0] IFControl,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  ex_op,
  output logic [3:0]  ex_rd,
  output logic        ex_we,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_BNE   = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;

  logic [31:0] rf_q [16];

  logic        replayValid_q, replayValid_d;
  logic [31:0] replayIns_q, replayIns_d;
  logic        kill_q, kill_d;
  logic [3:0]  sbEx_q, sbEx_d;
  logic [3:0]  sbMem_q, sbMem_d;
`ifndef ID_BYPASS_EN
  logic [3:0]  sbWb_q, sbWb_d;
`endif

  logic        exValid_q, exValid_d;
  logic [3:0]  exOp_q, exOp_d;
  logic [3:0]  exRd_q, exRd_d;
  logic        exWe_q, exWe_d;
  logic [31:0] exA_q, exA_d;
  logic [31:0] exB_q, exB_d;
  logic [31:0] exImm_q, exImm_d;

  logic [31:0] active;
  logic [3:0]  op, rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] immExt, rs1Val, rs2Val;
  logic        usesRs1, usesRs2, writesRd;
  logic        pend1, pend2, stall, taken;

  // A pending replay wins over fetch; the word after a taken branch is dropped.
  always_comb begin
    active = ins;
    if (replayValid_q) active = replayIns_q;
    else if (kill_q)   active = '0;
  end

  always_comb begin
    op = active[31:28];
    if (op > OP_JUMP) op = OP_NOP;
    rd     = active[27:24];
    rs1    = active[23:20];
    rs2    = active[19:16];
    imm    = active[15:0];
    immExt = {{16{imm[15]}}, imm};
  end

  always_comb begin
    usesRs1  = 1'b0;
    usesRs2  = 1'b0;
    writesRd = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        usesRs1  = 1'b1;
        usesRs2  = 1'b1;
        writesRd = (rd != 4'h0);
      end
      OP_ADDI, OP_LOAD: begin
        usesRs1  = 1'b1;
        writesRd = (rd != 4'h0);
      end
      OP_STORE, OP_BEQ, OP_BNE: begin
        usesRs1 = 1'b1;
        usesRs2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rs1Val = (rs1 == 4'h0) ? 32'h0 : rf_q[rs1];
    rs2Val = (rs2 == 4'h0) ? 32'h0 : rf_q[rs2];
`ifdef ID_BYPASS_EN
    if (wb_we && rs1 != 4'h0 && wb_addr == rs1) rs1Val = wb_data;
    if (wb_we && rs2 != 4'h0 && wb_addr == rs2) rs2Val = wb_data;
`endif
  end

  // Empty scoreboard slots hold 0, so the non-zero source check also rejects them.
  always_comb begin
    pend1 = (rs1 == sbEx_q) || (rs1 == sbMem_q);
    pend2 = (rs2 == sbEx_q) || (rs2 == sbMem_q);
`ifndef ID_BYPASS_EN
    pend1 = pend1 || (rs1 == sbWb_q);
    pend2 = pend2 || (rs2 == sbWb_q);
`endif
    stall = (usesRs1 && rs1 != 4'h0 && pend1) ||
            (usesRs2 && rs2 != 4'h0 && pend2);
    taken = !stall && ((op == OP_JUMP) ||
                       (op == OP_BEQ && rs1Val == rs2Val) ||
                       (op == OP_BNE && rs1Val != rs2Val));
  end

  always_comb begin
    IFControl = {1'b1, 2'b00, 32'h0};
    if (!reset) begin
      if (stall)      IFControl = '0;
      else if (taken) IFControl = {1'b1, 1'b1, 1'b1, 14'b0, imm, 2'b00};
    end
  end

  always_comb begin
    replayValid_d = stall;
    replayIns_d   = stall ? active : replayIns_q;
    kill_d        = taken;
    sbEx_d        = (!stall && writesRd) ? rd : 4'h0;
    sbMem_d       = sbEx_q;
`ifndef ID_BYPASS_EN
    sbWb_d        = sbMem_q;
`endif
    exValid_d = 1'b0;
    exOp_d    = 4'h0;
    exRd_d    = 4'h0;
    exWe_d    = 1'b0;
    exA_d     = 32'h0;
    exB_d     = 32'h0;
    exImm_d   = 32'h0;
    if (!stall) begin
      exValid_d = (op != OP_NOP);
      exOp_d    = op;
      exRd_d    = rd;
      exWe_d    = writesRd;
      exA_d     = rs1Val;
      exB_d     = rs2Val;
      exImm_d   = immExt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= 32'h0;
    end else if (!delay && wb_we && wb_addr != 4'h0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      replayValid_q <= 1'b0;
      replayIns_q   <= 32'h0;
      kill_q        <= 1'b0;
      sbEx_q        <= 4'h0;
      sbMem_q       <= 4'h0;
`ifndef ID_BYPASS_EN
      sbWb_q        <= 4'h0;
`endif
      exValid_q     <= 1'b0;
      exOp_q        <= 4'h0;
      exRd_q        <= 4'h0;
      exWe_q        <= 1'b0;
      exA_q         <= 32'h0;
      exB_q         <= 32'h0;
      exImm_q       <= 32'h0;
    end else if (!delay) begin
      replayValid_q <= replayValid_d;
      replayIns_q   <= replayIns_d;
      kill_q        <= kill_d;
      sbEx_q        <= sbEx_d;
      sbMem_q       <= sbMem_d;
`ifndef ID_BYPASS_EN
      sbWb_q        <= sbWb_d;
`endif
      exValid_q     <= exValid_d;
      exOp_q        <= exOp_d;
      exRd_q        <= exRd_d;
      exWe_q        <= exWe_d;
      exA_q         <= exA_d;
      exB_q         <= exB_d;
      exImm_q       <= exImm_d;
    end
  end

  assign ex_valid = exValid_q;
  assign ex_op    = exOp_q;
  assign ex_rd    = exRd_q;
  assign ex_we    = exWe_q;
  assign ex_a     = exA_q;
  assign ex_b     = exB_q;
  assign ex_imm   = exImm_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected EX contents are queued at drive time and popped after the edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, delay, wb_we;
  logic [31:0] ins, wb_data;
  logic [3:0]  wb_addr;
  logic [34:0] IFControl;
  logic        ex_valid, ex_we;
  logic [3:0]  ex_op, ex_rd;
  logic [31:0] ex_a, ex_b, ex_imm;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .delay(delay), .ins(ins), .IFControl(IFControl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
  );

`ifdef ID_BYPASS_EN
  localparam int STALLS = 2;
`else
  localparam int STALLS = 3;
`endif
  localparam logic [34:0] IFC_NORMAL = {1'b1, 2'b00, 32'h0};
  localparam logic [34:0] IFC_STALL  = 35'h0;

  typedef struct {
    logic        full;
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } exp_t;

  exp_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  function automatic logic [31:0] enc(logic [3:0] op, logic [3:0] rd, logic [3:0] rs1,
                                      logic [3:0] rs2, logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic exp_t mk(logic full, logic valid, logic [3:0] op, logic [3:0] rd,
                              logic we, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    exp_t e;
    e.full = full; e.valid = valid; e.op = op; e.rd = rd;
    e.we = we; e.a = a; e.b = b; e.imm = imm;
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic logic [34:0] ifcTaken(logic [15:0] imm);
    return {1'b1, 1'b1, 1'b1, 14'b0, imm, 2'b00};
  endfunction

  task automatic cmp(string tag, logic [63:0] observed, logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(string tag);
    exp_t e;
    testsRun++;
    assert (expQ.size() != 0) else begin
      testsFailed++;
      $error("[TB] FAIL %s.queue observed=empty expected=entry", tag);
      return;
    end
    e = expQ.pop_front();
    cmp({tag, ".ex_valid"}, 64'(ex_valid), 64'(e.valid));
    cmp({tag, ".ex_op"},    64'(ex_op),    64'(e.op));
    cmp({tag, ".ex_we"},    64'(ex_we),    64'(e.we));
    if (e.full) begin
      cmp({tag, ".ex_rd"},  64'(ex_rd),  64'(e.rd));
      cmp({tag, ".ex_a"},   64'(ex_a),   64'(e.a));
      cmp({tag, ".ex_b"},   64'(ex_b),   64'(e.b));
      cmp({tag, ".ex_imm"}, 64'(ex_imm), 64'(e.imm));
    end
  endtask

  // One clock: drive inputs, check combinational IFControl, queue the EX expectation, check after the edge.
  task automatic applyStimulus(string tag, logic [31:0] instr, logic dly, logic wbWe,
                               logic [3:0] wbAddr, logic [31:0] wbData,
                               logic [34:0] expIfc, exp_t e);
    ins = instr; delay = dly; wb_we = wbWe; wb_addr = wbAddr; wb_data = wbData;
    #2;
    cmp({tag, ".ifc"}, 64'(IFControl), 64'(expIfc));
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] addInstr, subInstr, junk;
    addInstr = enc(4'h1, 4'h2, 4'h1, 4'h1, 16'h0);
    subInstr = enc(4'h2, 4'h9, 4'h8, 4'h0, 16'h0);
    junk     = enc(4'h5, 4'h7, 4'h0, 4'h0, 16'h9);

    // Reset beats delay and a pending write to R5; a JUMP on ins must not reach IFControl.
    reset = 1'b1; delay = 1'b1; wb_we = 1'b1; wb_addr = 4'h5; wb_data = 32'hDEAD_BEEF;
    ins = enc(4'hA, 4'h0, 4'h0, 4'h0, 16'h0010);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.ifc",      64'(IFControl), 64'(IFC_NORMAL));
    cmp("reset.ex_valid", 64'(ex_valid), 64'h0);
    cmp("reset.ex_op",    64'(ex_op),    64'h0);
    cmp("reset.ex_rd",    64'(ex_rd),    64'h0);
    cmp("reset.ex_we",    64'(ex_we),    64'h0);
    cmp("reset.ex_a",     64'(ex_a),     64'h0);
    cmp("reset.ex_b",     64'(ex_b),     64'h0);
    cmp("reset.ex_imm",   64'(ex_imm),   64'h0);
    reset = 1'b0;

    applyStimulus("addi_r1", enc(4'h5, 4'h1, 4'h0, 4'h0, 16'd5), 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h5, 4'h1, 1, 0, 0, 32'd5));

    // RAW on R1: R1 is written back during the second stall cycle.
    applyStimulus("add_stall0", addInstr, 0, 0, 0, 0, IFC_STALL, bubble());
    applyStimulus("add_stall1", addInstr, 0, 1, 4'h1, 32'd5, IFC_STALL, bubble());
    for (int i = 2; i < STALLS; i++)
      applyStimulus("add_stall2", addInstr, 0, 0, 0, 0, IFC_STALL, bubble());
    applyStimulus("add_issue", junk, 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h1, 4'h2, 1, 32'd5, 32'd5, 0));

    applyStimulus("jump", enc(4'hA, 4'h0, 4'h0, 4'h0, 16'h0010), 0, 0, 0, 0,
                  ifcTaken(16'h0010), mk(1, 1, 4'hA, 4'h0, 0, 0, 0, 32'h10));
    applyStimulus("jump_kill", enc(4'h5, 4'h5, 4'h0, 4'h0, 16'd7), 0, 0, 0, 0,
                  IFC_NORMAL, bubble());

    applyStimulus("beq", enc(4'h8, 4'h0, 4'h0, 4'h0, 16'h0004), 0, 0, 0, 0,
                  ifcTaken(16'h0004), mk(1, 1, 4'h8, 4'h0, 0, 0, 0, 32'h4));
    applyStimulus("beq_kill", enc(4'h5, 4'h5, 4'h0, 4'h0, 16'd7), 0, 0, 0, 0,
                  IFC_NORMAL, bubble());
    applyStimulus("bne", enc(4'h9, 4'h0, 4'h0, 4'h0, 16'h0004), 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h9, 4'h0, 0, 0, 0, 32'h4));
    applyStimulus("addi_neg", enc(4'h5, 4'h6, 4'h0, 4'h0, 16'hFFFE), 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h5, 4'h6, 1, 0, 0, 32'hFFFF_FFFE));

    // Stall on R8, freeze for three cycles (a write to R10 during the freeze is dropped), then resume.
    applyStimulus("addi_r8", enc(4'h5, 4'h8, 4'h0, 4'h0, 16'd3), 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h5, 4'h8, 1, 0, 0, 32'd3));
    applyStimulus("sub_stall", subInstr, 0, 0, 0, 0, IFC_STALL, bubble());
    for (int i = 0; i < 3; i++)
      applyStimulus("sub_delay", junk, 1, 1, 4'hA, 32'h55, IFC_STALL, bubble());
    for (int i = 1; i < STALLS; i++)
      applyStimulus("sub_resume", junk, 0, (i == 1), 4'h8, 32'd3, IFC_STALL, bubble());
    applyStimulus("sub_issue", junk, 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h2, 4'h9, 1, 32'd3, 0, 0));

    applyStimulus("r0_write", 32'h0, 0, 1, 4'h0, 32'hFFFF_FFFF, IFC_NORMAL, bubble());
    applyStimulus("add_r0", enc(4'h1, 4'h3, 4'h0, 4'h0, 16'h0), 0, 1, 4'h0, 32'hFFFF_FFFF,
                  IFC_NORMAL, mk(1, 1, 4'h1, 4'h3, 1, 0, 0, 0));
    applyStimulus("add_r5_r10", enc(4'h1, 4'h4, 4'h5, 4'hA, 16'h0), 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h1, 4'h4, 1, 0, 0, 0));

`ifdef ID_BYPASS_EN
    applyStimulus("wt_same", enc(4'h1, 4'hC, 4'h7, 4'h0, 16'h0), 0, 1, 4'h7, 32'h1234,
                  IFC_NORMAL, mk(1, 1, 4'h1, 4'hC, 1, 32'h1234, 0, 0));
`else
    applyStimulus("wt_same", enc(4'h1, 4'hC, 4'h7, 4'h0, 16'h0), 0, 1, 4'h7, 32'h1234,
                  IFC_NORMAL, mk(1, 1, 4'h1, 4'hC, 1, 32'h0, 0, 0));
`endif
    applyStimulus("wt_after", enc(4'h1, 4'hD, 4'h7, 4'h0, 16'h0), 0, 0, 0, 0,
                  IFC_NORMAL, mk(1, 1, 4'h1, 4'hD, 1, 32'h1234, 0, 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
